// File: rtl/nios2_debug_host_jtag_master_if.sv
// Command/response channel between a system-clock master and the virtual-JTAG host sequencer.
interface nios2_debug_host_jtag_master_if #(
    parameter int DR_W = 38
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_ir;
    logic [DR_W-1:0] cmd_data;
    logic            rsp_valid;
    logic [DR_W-1:0] rsp_data;
    logic [1:0]      rsp_ir_out;
    logic            busy;

    modport master (
        output cmd_valid, cmd_ir, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out, busy
    );
    modport slave (
        input  cmd_valid, cmd_ir, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out, busy
    );
endinterface

// File: rtl/nios2_debug_host_jtag_master.sv
// Host-side virtual-JTAG initiator: runs UIR/CDR/SDR/UDR/RTI for one command on a clk-derived tck.
// Optional JTAG_DBG_IR_CACHE_EN skips UIR when the IR matches the previously issued one.
module nios2_debug_host_jtag_master #(
    parameter int DR_W       = 38,
    parameter int TCK_HALF   = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    nios2_debug_host_jtag_master_if.slave        bus,
    output logic                                 vji_tck,
    output logic                                 vji_tdi,
    input  logic                                 vji_tdo,
    output logic [1:0]                           vji_ir_in,
    input  logic [1:0]                           vji_ir_out,
    output logic                                 vji_uir,
    output logic                                 vji_cdr,
    output logic                                 vji_sdr,
    output logic                                 vji_udr,
    output logic                                 vji_rti
);
    localparam int HC_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam int BC_W = (DR_W > 1) ? $clog2(DR_W) : 1;
    localparam int RC_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
    localparam logic [HC_W-1:0] HALF_LAST = HC_W'(TCK_HALF - 1);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DR_W - 1);
    localparam logic [RC_W-1:0] RTI_LAST  = RC_W'(RTI_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE} state_t;

    state_t          state;
    logic [HC_W-1:0] half_cnt;
    logic [BC_W-1:0] bit_cnt;
    logic [RC_W-1:0] rti_cnt;
    logic [DR_W-1:0] sh;
    logic [DR_W-1:0] cap;
    logic [1:0]      ir_cap;
    logic            active, half_end, rise, fall, ir_hit;

    assign active   = (state != S_IDLE) && (state != S_DONE);
    assign half_end = (half_cnt == HALF_LAST);
    assign rise     = active && half_end && !vji_tck;
    assign fall     = active && half_end && vji_tck;
    assign bus.busy = (state != S_IDLE);

`ifdef JTAG_DBG_IR_CACHE_EN
    logic       cache_vld;
    logic [1:0] cache_ir;
    assign ir_hit = cache_vld && (cache_ir == bus.cmd_ir);
`else
    assign ir_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            half_cnt       <= '0;
            bit_cnt        <= '0;
            rti_cnt        <= '0;
            sh             <= '0;
            cap            <= '0;
            ir_cap         <= '0;
            bus.cmd_ready  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_ir_out <= '0;
            vji_tck        <= 1'b0;
            vji_tdi        <= 1'b0;
            vji_ir_in      <= '0;
            vji_uir        <= 1'b0;
            vji_cdr        <= 1'b0;
            vji_sdr        <= 1'b0;
            vji_udr        <= 1'b0;
            vji_rti        <= 1'b0;
`ifdef JTAG_DBG_IR_CACHE_EN
            cache_vld      <= 1'b0;
            cache_ir       <= '0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        vji_ir_in     <= bus.cmd_ir;
                        sh            <= bus.cmd_data;
                        half_cnt      <= '0;
                        vji_tck       <= 1'b0;
                        if (ir_hit) begin
                            state   <= S_CDR;
                            vji_cdr <= 1'b1;
                        end else begin
                            state   <= S_UIR;
                            vji_uir <= 1'b1;
                        end
`ifdef JTAG_DBG_IR_CACHE_EN
                        cache_vld <= 1'b1;
                        cache_ir  <= bus.cmd_ir;
`endif
                    end
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    bus.cmd_ready <= 1'b1;
                end
                default: begin
                    half_cnt <= half_end ? '0 : half_cnt + 1'b1;
                    if (half_end)
                        vji_tck <= !vji_tck;
                    // Slave outputs are captured on the clk that raises tck.
                    if (rise) begin
                        if (state == S_UIR) ir_cap <= vji_ir_out;
                        if (state == S_SDR) cap <= {vji_tdo, cap[DR_W-1:1]};
                    end
                    // Falling tck closes a period; the next step's strobes and tdi launch here.
                    if (fall) begin
                        case (state)
                            S_UIR: begin
                                state   <= S_CDR;
                                vji_uir <= 1'b0;
                                vji_cdr <= 1'b1;
                            end
                            S_CDR: begin
                                state   <= S_SDR;
                                vji_cdr <= 1'b0;
                                vji_sdr <= 1'b1;
                                bit_cnt <= '0;
                                vji_tdi <= sh[0];
                                sh      <= {1'b0, sh[DR_W-1:1]};
                            end
                            S_SDR: begin
                                if (bit_cnt == BIT_LAST) begin
                                    state   <= S_UDR;
                                    vji_sdr <= 1'b0;
                                    vji_udr <= 1'b1;
                                    vji_tdi <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    vji_tdi <= sh[0];
                                    sh      <= {1'b0, sh[DR_W-1:1]};
                                end
                            end
                            S_UDR: begin
                                state   <= S_RTI;
                                vji_udr <= 1'b0;
                                vji_rti <= 1'b1;
                                rti_cnt <= '0;
                            end
                            S_RTI: begin
                                if (rti_cnt == RTI_LAST) begin
                                    state          <= S_DONE;
                                    vji_rti        <= 1'b0;
                                    bus.rsp_valid  <= 1'b1;
                                    bus.rsp_data   <= cap;
                                    bus.rsp_ir_out <= ir_cap;
                                end else begin
                                    rti_cnt <= rti_cnt + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule
